// File: rtl/alu_pkg.sv
// Shared opcode encoding and status-flag bit positions for the ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_INC    = 3'b101,
        OP_PASS_A = 3'b110,
        OP_PASS_B = 3'b111
    } opcode_e;

    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result and {overflow, negative, zero} status.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned BW = 16
) (
    input  logic [BW-1:0] in_a_i,
    input  logic [BW-1:0] in_b_i,
    input  logic [2:0]    opcode_i,
    output logic [BW-1:0] result_o,
    output logic [2:0]    flags_o
);

    localparam logic [BW-1:0] One = {{(BW-1){1'b0}}, 1'b1};

    opcode_e       op;
    logic [BW-1:0] result;
    logic          ovf;
    logic          sign_a;
    logic          sign_b;
    logic          sign_r;

    assign op     = opcode_e'(opcode_i);
    assign sign_a = in_a_i[BW-1];
    assign sign_b = in_b_i[BW-1];
    assign sign_r = result[BW-1];

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = in_a_i + in_b_i;
                ovf    = (sign_a == sign_b) && (sign_r != sign_a);
            end
            OP_SUB: begin
                result = in_a_i - in_b_i;
                ovf    = (sign_a != sign_b) && (sign_r != sign_a);
            end
            OP_AND:    result = in_a_i & in_b_i;
            OP_OR:     result = in_a_i | in_b_i;
            OP_XOR:    result = in_a_i ^ in_b_i;
            OP_INC: begin
                result = in_a_i + One;
                // Only the most positive value can wrap when adding one.
                ovf    = !sign_a && sign_r;
            end
            OP_PASS_A: result = in_a_i;
            OP_PASS_B: result = in_b_i;
            default:   result = '0;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_V] = ovf;
        flags_o[FLAG_N] = sign_r;
        flags_o[FLAG_Z] = (result == '0);
    end

    assign result_o = result;

endmodule

// File: rtl/alu.sv
// Registered signed ALU: combinational core followed by the result/flag register.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned BW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] in_a,
    input  logic [BW-1:0] in_b,
    input  logic [2:0]    opcode,
    output logic [BW-1:0] out,
    output logic [2:0]    flags
);

    logic [BW-1:0] out_d;
    logic [BW-1:0] out_q;
    logic [2:0]    flags_d;
    logic [2:0]    flags_q;

    alu_core #(
        .BW(BW)
    ) u_core (
        .in_a_i   (in_a),
        .in_b_i   (in_b),
        .opcode_i (opcode),
        .result_o (out_d),
        .flags_o  (flags_d)
    );

    // Reset value keeps the zero flag consistent with out == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flags_q <= 3'b001;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign out   = out_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned BW = 16;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [2:0]    opcode;
    logic [BW-1:0] out;
    logic [2:0]    flags;

    int checks = 0;
    int errors = 0;

    alu #(
        .BW(BW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_a   (in_a),
        .in_b   (in_b),
        .opcode (opcode),
        .out    (out),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int exp_out, input logic [2:0] exp_flags);
        logic [BW-1:0] e_out;
        e_out = BW'(exp_out);
        checks++;
        assert (out === e_out && flags === exp_flags)
        else begin
            errors++;
            $error("FAIL %s: out=%h flags=%b, expected out=%h flags=%b",
                   tag, out, flags, e_out, exp_flags);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic do_op(input string tag, input opcode_e op, input int a, input int b,
                         input int exp_out, input logic [2:0] exp_flags);
        @(negedge clk);
        opcode = op;
        in_a   = BW'(a);
        in_b   = BW'(b);
        @(posedge clk);
        #1;
        check(tag, exp_out, exp_flags);
    endtask

    initial begin
        rst_n  = 1'b1;
        in_a   = 16'h1234;
        in_b   = 16'h4321;
        opcode = OP_ADD;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_3_4", OP_ADD, 3, 4, 7, 3'b000);
        do_op("add_16000", OP_ADD, 16000, 16000, 32000, 3'b000);
        do_op("add_ovf_pos", OP_ADD, 20000, 20000, -25536, 3'b110);
        do_op("add_neg", OP_ADD, -100, -200, -300, 3'b010);
        do_op("add_zero", OP_ADD, 0, 0, 0, 3'b001);
        do_op("add_min_min", OP_ADD, -32768, -32768, 0, 3'b101);

        do_op("sub_ovf", OP_SUB, -20000, 20000, 25536, 3'b100);
        do_op("sub_neg", OP_SUB, -5, 10, -15, 3'b010);
        do_op("sub_zero", OP_SUB, 0, 0, 0, 3'b001);
        do_op("sub_equal", OP_SUB, 7, 7, 0, 3'b001);
        do_op("sub_min_1", OP_SUB, -32768, 1, 32767, 3'b100);
        do_op("sub_no_ovf_diff", OP_SUB, 5, -3, 8, 3'b000);

        do_op("and", OP_AND, 'h0F0F, 'h00FF, 'h000F, 3'b000);
        do_op("or", OP_OR, 'h0F0F, 'h00FF, 'h0FFF, 3'b000);
        do_op("xor", OP_XOR, 'h0F0F, 'h00FF, 'h0FF0, 3'b000);
        do_op("and_zero", OP_AND, 0, 0, 0, 3'b001);
        do_op("or_zero", OP_OR, 0, 0, 0, 3'b001);
        do_op("xor_zero", OP_XOR, 0, 0, 0, 3'b001);
        do_op("and_neg", OP_AND, 'hF000, 'h8FFF, 'h8000, 3'b010);
        do_op("xor_same", OP_XOR, 'h5A5A, 'h5A5A, 0, 3'b001);

        do_op("inc_m1", OP_INC, -1, 'h1234, 0, 3'b001);
        do_op("inc_max", OP_INC, 32767, 0, -32768, 3'b110);
        do_op("inc_m500", OP_INC, -500, 77, -499, 3'b010);
        do_op("inc_min", OP_INC, -32768, 0, -32767, 3'b010);

        do_op("pass_a_zero", OP_PASS_A, 0, 1, 0, 3'b001);
        do_op("pass_b_zero", OP_PASS_B, 1, 0, 0, 3'b001);
        do_op("pass_b_neg", OP_PASS_B, 3, -7, -7, 3'b010);
        do_op("pass_a_max", OP_PASS_A, 32767, -1, 32767, 3'b000);

        // Load a nonzero result, then reset mid-cycle: it must clear without a clock edge.
        do_op("pre_reset", OP_ADD, 100, 23, 123, 3'b000);
        @(negedge clk);
        opcode = OP_PASS_A;
        in_a   = 16'h7777;
        rst_n  = 1'b0;
        #1;
        check("reset_mid", 0, 3'b001);
        @(posedge clk);
        #1;
        check("reset_held", 0, 3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", OP_SUB, 10, 3, 7, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterised signed two's-complement ALU with eight operations selected by a 3-bit opcode.
- Produces a registered result and a 3-bit status word {overflow, negative, zero}.
- Sits in the datapath as the single execute unit.
- Output is registered on `clk` with asynchronous active-low reset `rst_n`.

Parameters:
- BW, 16, data bitwidth of operands and result (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_a  input  BW  signed operand A.
- in_b  input  BW  signed operand B.
- opcode  input  3  operation select.
- out  output  BW  signed registered result.
- flags  output  3  registered status: flags[2]=overflow, flags[1]=negative, flags[0]=zero.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: on rst_n=0, immediately and independent of clk, out=0 and flags=3'b001 (zero flag consistent with out=0). Reset asserted mid-operation discards any pending result.
- Latency: operands and opcode are sampled on a rising clk edge. out/flags reflect them after that edge (1-cycle latency). A new operation is accepted every cycle. No handshake.
- Opcodes (all arithmetic modulo 2^BW, result truncated to BW bits):
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND: a&b.
  - 011 OR: a|b.
  - 100 XOR: a^b.
  - 101 INC: a+1 (in_b ignored).
  - 110 PASS_A: a.
  - 111 PASS_B: b.
- Overflow flag (signed):
  - ADD: set when a and b have the same sign and the result sign differs.
  - SUB: set when a and b differ in sign and the result sign differs from a.
  - INC: set only when a = 2^(BW-1)-1 (0x7FFF).
  - Logical/pass ops: always 0.
- Negative flag: MSB of the truncated result. It is set on wrapped overflow results, e.g. 20000+20000 → out=-25536, flags=110.
- Zero flag: set iff the truncated result == 0. It is independent of overflow; e.g. -32768 + -32768 gives out=0, flags=101.
- Boundaries:
  - INC of -1 gives 0 with flags 001.
  - INC of 0x7FFF gives 0x8000 with flags 110.
  - SUB of -32768-1 gives 32767 with flags 100.
  - No X propagation: unknown opcodes cannot occur (3-bit space fully decoded).

Decomposition:
- Package alu_pkg:
  - Enum opcode_e (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_PASS_A, OP_PASS_B).
  - Flag index constants FLAG_V=2, FLAG_N=1, FLAG_Z=0.
- Combinational sub-module alu_core: computes next result and flags from in_a/in_b/opcode.
- Top alu: holds only the output register with async reset.

Test Plan:
- Reset: assert rst_n=0 with nonzero inputs → out=0, flags=001 without waiting for a clock edge. Deassert, then ADD 3+4 → out=7, flags=000 after one edge.
- ADD:
  - 16000+16000 → 32000, flags 000.
  - 20000+20000 → -25536, flags 110.
  - -100+-200 → -300, flags 010.
  - 0+0 → 0, flags 001.
- SUB:
  - -20000-20000 → 25536, flags 100.
  - -5-10 → -15, flags 010.
  - 0-0 → 0, flags 001.
  - 7-7 → 0, flags 001.
- Logic ops with a=0x0F0F, b=0x00FF:
  - AND → 0x000F, flags 000.
  - OR → 0x0FFF, flags 000.
  - XOR → 0x0FF0, flags 000.
  - Each op with a=b=0 → flags 001.
- INC:
  - a=-1 → 0, flags 001.
  - a=32767 → -32768, flags 110.
  - a=-500 → -499, flags 010.
- Pass ops:
  - PASS_A with a=0, b=1 → 0, flags 001.
  - PASS_B with a=1, b=0 → 0, flags 001.
  - PASS_B with b=-7 → -7, flags 010.
- Back-to-back: change opcode every cycle; each out matches the operation from the previous edge.
